i2c_txn_scheduler: RTL and testbench

I2C_TXN_SCHEDULER -- requirements
Module: i2c_txn_scheduler

---
 rtl/i2c_txn_scheduler.sv | 150 +++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler
//   Buffers one write and one read request from the AXI slave side and
//   schedules them, one at a time, onto a simple I2C master handshake.
//   Contended grants alternate between write and read.
//
// Ports
//   aclk, areset              clock, synchronous active-high reset
//   wr_req / wr_addr_data     write request and payload, wr_req_ready = slot free
//   rd_req / rd_addr          read request and address, rd_req_ready = slot free
//   wr_done / wr_err          one-cycle write completion, error qualified by it
//   rd_data_valid / rd_data / rd_err   one-cycle read completion with result
//   pending_wr / pending_rd   slot occupied (held or in flight)
//   i2c_start / i2c_rw / i2c_addr_data  launch to the I2C master
//   i2c_done / i2c_nack / i2c_rdata     completion from the I2C master
module i2c_txn_scheduler #(
    parameter int ADDR_DATA_W = 40,
    parameter int RDATA_W     = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   wr_req,
    input  logic [ADDR_DATA_W-1:0] wr_addr_data,
    output logic                   wr_req_ready,
    input  logic                   rd_req,
    input  logic [ADDR_DATA_W-1:0] rd_addr,
    output logic                   rd_req_ready,
    output logic                   wr_done,
    output logic                   wr_err,
    output logic                   rd_data_valid,
    output logic [RDATA_W-1:0]     rd_data,
    output logic                   rd_err,
    output logic                   pending_wr,
    output logic                   pending_rd,
    output logic                   i2c_start,
    output logic                   i2c_rw,
    output logic [ADDR_DATA_W-1:0] i2c_addr_data,
    input  logic                   i2c_done,
    input  logic                   i2c_nack,
    input  logic [RDATA_W-1:0]     i2c_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_DATA_W-1:0] wr_hold, rd_hold;
    logic                   last_grant_rd;  // 1 = last grant went to the read
    logic                   grant_rd;
    logic [CNT_W-1:0]       cnt;
    logic                   err_q;
    logic [RDATA_W-1:0]     rd_data_q;
    logic                   rw_q;
    logic [ADDR_DATA_W-1:0] addr_data_q;

    assign wr_req_ready  = ~pending_wr;
    assign rd_req_ready  = ~pending_rd;
    assign i2c_rw        = rw_q;
    assign i2c_addr_data = addr_data_q;
    assign rd_data       = rd_data_q;
    assign wr_err        = wr_done & err_q;
    assign rd_err        = rd_data_valid & err_q;

    // Round-robin only matters under contention; a lone request always wins.
    assign grant_rd = (pending_wr && pending_rd) ? ~last_grant_rd : pending_rd;

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        i2c_start     = 1'b0;
        wr_done       = 1'b0;
        rd_data_valid = 1'b0;
        case (state)
            IDLE:      if (pending_wr || pending_rd) state_nxt = ISSUE;
            ISSUE: begin
                i2c_start = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (i2c_done || cnt == CNT_LAST) state_nxt = RESP;
            RESP: begin
                wr_done       = ~rw_q;
                rd_data_valid = rw_q;
                state_nxt     = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pending_wr    <= 1'b0;
            pending_rd    <= 1'b0;
            wr_hold       <= '0;
            rd_hold       <= '0;
            last_grant_rd <= 1'b1;
            cnt           <= '0;
            err_q         <= 1'b0;
            rd_data_q     <= '0;
            rw_q          <= 1'b0;
            addr_data_q   <= '0;
        end else begin
            if (wr_req && !pending_wr) begin
                pending_wr <= 1'b1;
                wr_hold    <= wr_addr_data;
            end
            if (rd_req && !pending_rd) begin
                pending_rd <= 1'b1;
                rd_hold    <= rd_addr;
            end
            case (state)
                IDLE: begin
                    // Latch the grant here so rw/payload are stable from ISSUE on.
                    if (pending_wr || pending_rd) begin
                        rw_q        <= grant_rd;
                        addr_data_q <= grant_rd ? rd_hold : wr_hold;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
                WAIT_DONE: begin
                    if (i2c_done) begin
                        err_q <= i2c_nack;
                        if (rw_q) rd_data_q <= i2c_rdata;
                    end else if (cnt == CNT_LAST) begin
                        err_q <= 1'b1;
                        if (rw_q) rd_data_q <= '0;
                    end else begin
                        // Leaving on CNT_LAST, so the counter never wraps here.
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rw_q) pending_rd <= 1'b0;
                    else      pending_wr <= 1'b0;
                    last_grant_rd <= rw_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
module tb_i2c_txn_scheduler;
    localparam int AW = 40;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          aclk, areset;
    logic          wr_req, wr_req_ready, rd_req, rd_req_ready;
    logic [AW-1:0] wr_addr_data, rd_addr, i2c_addr_data;
    logic          wr_done, wr_err, rd_data_valid, rd_err;
    logic [DW-1:0] rd_data, i2c_rdata;
    logic          pending_wr, pending_rd;
    logic          i2c_start, i2c_rw, i2c_done, i2c_nack;

    i2c_txn_scheduler #(.ADDR_DATA_W(AW), .RDATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .aclk(aclk), .areset(areset),
        .wr_req(wr_req), .wr_addr_data(wr_addr_data), .wr_req_ready(wr_req_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
        .wr_done(wr_done), .wr_err(wr_err),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
        .pending_wr(pending_wr), .pending_rd(pending_rd),
        .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr_data(i2c_addr_data),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {logic rw; logic [AW-1:0] ad;} iss_t;
    typedef struct packed {logic rd; logic err; logic [DW-1:0] data;} rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   pass_cnt = 0;
    int   total    = 0;
    int   starts_seen = 0;
    int   resps_seen  = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT launches or completes.
    always @(negedge aclk) begin
        iss_t ie;
        rsp_t re;
        if (i2c_start) begin
            starts_seen++;
            chk("start_expected", iss_q.size() > 0, 1);
            if (iss_q.size() > 0) begin
                ie = iss_q.pop_front();
                chk("start_rw", i2c_rw, ie.rw);
                chk("start_addr", i2c_addr_data, ie.ad);
            end
        end
        if (wr_done || rd_data_valid) begin
            resps_seen++;
            chk("resp_one_hot", wr_done & rd_data_valid, 0);
            chk("resp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
                re = rsp_q.pop_front();
                chk("resp_kind", rd_data_valid, re.rd);
                chk("resp_err", re.rd ? rd_err : wr_err, re.err);
                chk("resp_rw_stable", i2c_rw, re.rd);
                if (re.rd) chk("resp_rdata", rd_data, re.data);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send(logic w, logic [AW-1:0] wd, logic r, logic [AW-1:0] ra);
        if (w) chk("wr_ready_before", wr_req_ready, 1);
        if (r) chk("rd_ready_before", rd_req_ready, 1);
        wr_req = w; wr_addr_data = wd; rd_req = r; rd_addr = ra;
        @(posedge aclk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        if (w) begin
            chk("pending_wr_set", pending_wr, 1);
            chk("wr_ready_clr", wr_req_ready, 0);
        end
        if (r) begin
            chk("pending_rd_set", pending_rd, 1);
            chk("rd_ready_clr", rd_req_ready, 0);
        end
    endtask

    task automatic wait_start();
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            if (i2c_start) break;
        end
        chk("start_seen", i2c_start, 1);
    endtask

    // d posedges after the call, hold i2c_done for one cycle.
    task automatic pulse_done(int d, logic nack, logic [DW-1:0] rdat);
        repeat (d) @(posedge aclk);
        #1;
        i2c_done = 1'b1; i2c_nack = nack; i2c_rdata = rdat;
        @(posedge aclk); #1;
        i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0;
        wr_req = 0; rd_req = 0; wr_addr_data = '0; rd_addr = '0;
        i2c_done = 0; i2c_nack = 0; i2c_rdata = '0;
        areset = 1'b1;
        tick(3);
        chk("rst_wr_ready", wr_req_ready, 1);
        chk("rst_rd_ready", rd_req_ready, 1);
        chk("rst_pend_wr", pending_wr, 0);
        chk("rst_pend_rd", pending_rd, 0);
        chk("rst_start", i2c_start, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_rd_valid", rd_data_valid, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_i2c_rw", i2c_rw, 0);
        chk("rst_i2c_ad", i2c_addr_data, 0);
        areset = 1'b0;
        tick(1);

        // Contention right after reset: write first, then read.
        iss_q.push_back('{1'b0, 40'hA1_0000_0001});
        iss_q.push_back('{1'b1, 40'h00_0000_0B01});
        rsp_q.push_back('{1'b0, 1'b0, 32'h0});
        rsp_q.push_back('{1'b1, 1'b0, 32'h1111_2222});
        send(1, 40'hA1_0000_0001, 1, 40'h00_0000_0B01);
        wait_start();
        pulse_done(1, 0, 32'h0);
        chk("c1_wr_done_min_lat", wr_done, 1);
        wait_start();
        pulse_done(1, 0, 32'h1111_2222);
        chk("c1_rd_valid", rd_data_valid, 1);
        tick(2);

        // Second contention: write wins again.
        iss_q.push_back('{1'b0, 40'hA2_0000_0002});
        iss_q.push_back('{1'b1, 40'h00_0000_0B02});
        rsp_q.push_back('{1'b0, 1'b0, 32'h0});
        rsp_q.push_back('{1'b1, 1'b0, 32'h3333_4444});
        send(1, 40'hA2_0000_0002, 1, 40'h00_0000_0B02);
        wait_start();
        pulse_done(2, 0, 32'h0);
        wait_start();
        pulse_done(2, 0, 32'h3333_4444);
        tick(2);

        // Single write, done 3 cycles after start.
        iss_q.push_back('{1'b0, 40'h12_3300_0001});
        rsp_q.push_back('{1'b0, 1'b0, 32'h0});
        send(1, 40'h12_3300_0001, 0, '0);
        wait_start();
        pulse_done(3, 0, 32'h0);
        chk("sw_wr_done", wr_done, 1);
        chk("sw_wr_err", wr_err, 0);
        tick(1);
        chk("sw_pend_clr", pending_wr, 0);
        chk("sw_ready_back", wr_req_ready, 1);

        // Read with data.
        iss_q.push_back('{1'b1, 40'h00_0000_0dad});
        rsp_q.push_back('{1'b1, 1'b0, 32'h0000_0A0A});
        send(0, '0, 1, 40'h00_0000_0dad);
        wait_start();
        pulse_done(2, 0, 32'h0000_0A0A);
        chk("rd_valid", rd_data_valid, 1);
        chk("rd_data", rd_data, 32'h0000_0A0A);
        chk("rd_err", rd_err, 0);
        tick(2);

        // Read timeout: response after exactly 16 WAIT_DONE cycles.
        iss_q.push_back('{1'b1, 40'h00_0000_0077});
        rsp_q.push_back('{1'b1, 1'b1, 32'h0});
        send(0, '0, 1, 40'h00_0000_0077);
        wait_start();
        repeat (16) @(posedge aclk);
        #1;
        chk("to_not_early", rd_data_valid, 0);
        @(posedge aclk); #1;
        chk("to_valid", rd_data_valid, 1);
        chk("to_err", rd_err, 1);
        chk("to_data_zero", rd_data, 0);
        tick(2);

        // Done on the last WAIT_DONE cycle beats the timeout.
        iss_q.push_back('{1'b1, 40'h00_0000_0078});
        rsp_q.push_back('{1'b1, 1'b0, 32'h0000_BEEF});
        send(0, '0, 1, 40'h00_0000_0078);
        wait_start();
        pulse_done(16, 0, 32'h0000_BEEF);
        chk("to_edge_valid", rd_data_valid, 1);
        chk("to_edge_err", rd_err, 0);
        chk("to_edge_data", rd_data, 32'h0000_BEEF);
        tick(2);

        // NACKed write.
        iss_q.push_back('{1'b0, 40'h55_0000_00AA});
        rsp_q.push_back('{1'b0, 1'b1, 32'h0});
        send(1, 40'h55_0000_00AA, 0, '0);
        wait_start();
        pulse_done(2, 1, 32'hDEAD_0000);
        chk("nack_wr_done", wr_done, 1);
        chk("nack_wr_err", wr_err, 1);
        tick(1);
        chk("nack_pend_clr", pending_wr, 0);
        tick(1);

        // Reset during WAIT_DONE with the other request still held.
        // Last grant was the write, so the read goes first.
        iss_q.push_back('{1'b1, 40'h00_0000_00CD});
        send(1, 40'h00_0000_00AB, 1, 40'h00_0000_00CD);
        wait_start();
        tick(2);
        s0 = starts_seen;
        r0 = resps_seen;
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        chk("mid_rst_wr_ready", wr_req_ready, 1);
        chk("mid_rst_rd_ready", rd_req_ready, 1);
        chk("mid_rst_pend_wr", pending_wr, 0);
        chk("mid_rst_pend_rd", pending_rd, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        pulse_done(1, 0, 32'h5555_5555);
        tick(20);
        chk("mid_rst_no_resp", resps_seen, r0);
        chk("mid_rst_no_start", starts_seen, s0);
        chk("mid_rst_rd_data_late", rd_data, 0);

        chk("iss_q_drained", iss_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
